// File: rtl/idex_if.sv
// Decode/execute-side bundle for idex_stage: ID request, register file port,
// downstream bypass sources and the registered EX output.
interface idex_if #(
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_pc;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              id_is_load;
  logic [CTRL_W-1:0] id_ctrl;

  logic [4:0]        rf_addr1;
  logic [4:0]        rf_addr2;
  logic [31:0]       rf_reg1;
  logic [31:0]       rf_reg2;

  logic [31:0]       ex_res;
  logic              mem_valid;
  logic              mem_wen;
  logic              mem_is_load;
  logic [4:0]        mem_rd;
  logic [31:0]       mem_data;
  logic              wb_wen;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;

  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [31:0]       ex_op1;
  logic [31:0]       ex_op2;
  logic [4:0]        ex_rd;
  logic              ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
    input  id_rs1_used, id_rs2_used, id_is_load, id_ctrl,
    output id_ready,
    output rf_addr1, rf_addr2,
    input  rf_reg1, rf_reg2,
    input  ex_res,
    input  mem_valid, mem_wen, mem_is_load, mem_rd, mem_data,
    input  wb_wen, wb_rd, wb_data,
    input  flush, ex_ready,
    output ex_valid, ex_pc, ex_imm, ex_op1, ex_op2,
    output ex_rd, ex_is_load, ex_ctrl
  );

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
    output id_rs1_used, id_rs2_used, id_is_load, id_ctrl,
    input  id_ready,
    input  rf_addr1, rf_addr2,
    output rf_reg1, rf_reg2,
    output ex_res,
    output mem_valid, mem_wen, mem_is_load, mem_rd, mem_data,
    output wb_wen, wb_rd, wb_data,
    output flush, ex_ready,
    input  ex_valid, ex_pc, ex_imm, ex_op1, ex_op2,
    input  ex_rd, ex_is_load, ex_ctrl
  );
endinterface

// File: rtl/idex_stage.sv
// Operand read, hazard resolution and ID/EX register for the RV32I core.
// IDEX_FWD_EN enables the EX/MEM/WB bypass; otherwise hazards stall.
module idex_stage #(
  parameter int CTRL_W = 16
) (
  input logic  clk,
  input logic  rst,
  idex_if.slave bus
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [31:0]       op1;
    logic [31:0]       op2;
    logic [4:0]        rd;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  id_ex_t      q;
  id_ex_t      d;
  logic        v;
  logic        nz1, nz2;
  logic        ex1, ex2;
  logic        mem1, mem2;
  logic        wb1, wb2;
  logic        stall;
  logic        xfer;
  logic [31:0] op1, op2;

  assign bus.rf_addr1 = bus.id_rs1;
  assign bus.rf_addr2 = bus.id_rs2;

  assign nz1 = |bus.id_rs1;
  assign nz2 = |bus.id_rs2;

  assign ex1 = v & (|q.rd) & (q.rd == bus.id_rs1);
  assign ex2 = v & (|q.rd) & (q.rd == bus.id_rs2);

  assign mem1 = bus.mem_valid & bus.mem_wen & (|bus.mem_rd)
              & (bus.mem_rd == bus.id_rs1);
  assign mem2 = bus.mem_valid & bus.mem_wen & (|bus.mem_rd)
              & (bus.mem_rd == bus.id_rs2);

  assign wb1 = bus.wb_wen & (bus.wb_rd == bus.id_rs1);
  assign wb2 = bus.wb_wen & (bus.wb_rd == bus.id_rs2);

`ifdef IDEX_FWD_EN
  function automatic logic [31:0] pick(
    input logic        nz,
    input logic        e,
    input logic        m,
    input logic        w,
    input logic [31:0] rf,
    input logic [31:0] er,
    input logic [31:0] md,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = rf;
    if (!nz)    r = '0;
    else if (e) r = er;
    else if (m) r = md;
    else if (w) r = wd;
    return r;
  endfunction

  assign op1 = pick(nz1, ex1, mem1, wb1, bus.rf_reg1,
                    bus.ex_res, bus.mem_data, bus.wb_data);
  assign op2 = pick(nz2, ex2, mem2, wb2, bus.rf_reg2,
                    bus.ex_res, bus.mem_data, bus.wb_data);

  // Only a load result is unavailable in time for the bypass.
  assign stall =
      (bus.id_rs1_used & nz1 & ((ex1 & q.is_load) | (mem1 & bus.mem_is_load)))
    | (bus.id_rs2_used & nz2 & ((ex2 & q.is_load) | (mem2 & bus.mem_is_load)));
`else
  logic unused_fwd;

  assign op1 = nz1 ? bus.rf_reg1 : '0;
  assign op2 = nz2 ? bus.rf_reg2 : '0;

  // Wait until the producer has left write-back and the RF holds it.
  assign stall =
      (bus.id_rs1_used & nz1 & (ex1 | mem1 | wb1))
    | (bus.id_rs2_used & nz2 & (ex2 | mem2 | wb2));

  assign unused_fwd = ^{bus.ex_res, bus.mem_data, bus.wb_data,
                        bus.mem_is_load};
`endif

  assign bus.id_ready = ~bus.flush & ~stall & (~v | bus.ex_ready);
  assign xfer         = bus.id_valid & bus.id_ready;

  assign d = '{
    pc:      bus.id_pc,
    imm:     bus.id_imm,
    op1:     op1,
    op2:     op2,
    rd:      bus.id_rd,
    is_load: bus.id_is_load,
    ctrl:    bus.id_ctrl
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      q <= '0;
    end else if (bus.flush) begin
      v <= 1'b0;
    end else if (xfer) begin
      v <= 1'b1;
      q <= d;
    end else if (bus.ex_ready) begin
      v <= 1'b0;
    end
  end

  assign bus.ex_valid   = v;
  assign bus.ex_pc      = q.pc;
  assign bus.ex_imm     = q.imm;
  assign bus.ex_op1     = q.op1;
  assign bus.ex_op2     = q.op2;
  assign bus.ex_rd      = q.rd;
  assign bus.ex_is_load = q.is_load;
  assign bus.ex_ctrl    = q.ctrl;

endmodule

// File: doc/idex_stage.md
# idex_stage

Operand-read and ID/EX pipeline register for the RV32I core. Sits between decode and execute. It drives the register file read addresses and takes the register file's combinational `reg1`/`reg2` data. It resolves read-after-write hazards against in-flight instructions by bypassing or stalling, then registers the decoded instruction plus final operands for execute under a valid/ready handshake with flush.

## Interface
Parameters:
- `CTRL_W`, 16: width of the opaque decoded-control bundle passed through to execute.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `id_valid`  in  1: decode presents an instruction.
- `id_ready`  out  1: stage accepts it this cycle.
- `id_pc`, `id_imm`  in  32: PC and immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5: register indices.
- `id_rs1_used`, `id_rs2_used`  in  1: operand is actually read.
- `id_is_load`  in  1: instruction is a load.
- `id_ctrl`  in  CTRL_W: decoded control.
- `rf_addr1`, `rf_addr2`  out  5: register file read addresses, equal to `id_rs1`/`id_rs2` combinationally.
- `rf_reg1`, `rf_reg2`  in  32: register file read data.
- `ex_res`  in  32: execute result of the instruction currently in this stage's output register.
- `mem_valid`, `mem_wen`, `mem_is_load`  in  1: MEM-stage status.
- `mem_rd`  in  5: MEM-stage destination register.
- `mem_data`  in  32: MEM-stage result.
- `wb_wen`  in  1: write-back enable, same signal as the register file write enable.
- `wb_rd`  in  5: write-back destination register.
- `wb_data`  in  32: write-back data.
- `flush`  in  1: kill the instruction in this stage.
- `ex_valid`  out  1: output register holds a valid instruction.
- `ex_ready`  in  1: execute accepts it.
- `ex_pc`, `ex_imm`, `ex_op1`, `ex_op2`  out  32: registered PC, immediate and operands.
- `ex_rd`  out  5: registered destination register.
- `ex_is_load`  out  1: registered load flag.
- `ex_ctrl`  out  CTRL_W: registered control.

## Operation
- **Per-operand match terms.** For operand rsN, with `used` = `id_rsN_used` and rsN≠0:
  - EX match: `ex_valid` & `ex_rd`≠0 & `ex_rd`==rsN.
  - MEM match: `mem_valid` & `mem_wen` & `mem_rd`≠0 & `mem_rd`==rsN.
  - WB match: `wb_wen` & `wb_rd`==rsN.
- **Operand select (FWD_EN).** Priority is EX match → `ex_res`, then MEM match → `mem_data`, then WB match → `wb_data`, else `rf_regN`. If rsN==0 the operand is 0 regardless of any match.
- **Load-use stall.** `stall` is raised when a used operand has an EX match with `ex_is_load`, or a MEM match with `mem_is_load`.
- **Handshake.**
  - `id_ready` = ~`flush` & ~`stall` & (~`ex_valid` | `ex_ready`).
  - Transfer into the output register occurs when `id_valid` & `id_ready`.
- **Register update at each rising edge, in priority order:**
  1. `flush`: `ex_valid`←0.
  2. Transfer: all `ex_*` fields ← incoming fields and selected operands; `ex_valid`←1.
  3. `ex_ready` with no transfer: `ex_valid`←0. This is also where a stall inserts its bubble.
  4. Otherwise: hold every `ex_*` field.
- **Operand timing.** Operands are captured only on transfer. While held they never change, even if the bypass sources change.
- **Reset.** All `ex_*` outputs are 0, including `ex_valid`=0.
- **Reset mid-operation.** Asynchronous reset clears the output register immediately. `id_ready` then follows its equation with `ex_valid`=0.

## Timing
- Latency is one cycle from accepted `id_valid` to `ex_valid`.
- Throughput is one instruction per cycle with no hazard and `ex_ready`=1.
- Load followed by a dependent instruction: with FWD_EN there are 2 bubble cycles.
  - One cycle while the load is in EX.
  - One cycle while the load is in MEM.
  - The dependent instruction is then taken via the WB bypass.
- Same-cycle `wb_wen` write and ID read of the same register: the register file returns stale data, so the WB bypass (or, without FWD_EN, a stall) is mandatory.
- `flush` and `ex_ready`=0 in the same cycle: flush wins, and the instruction is dropped.
- `flush` with `id_valid`=1: nothing is accepted that cycle.

## Configuration
- `IDEX_FWD_EN` defined: the bypass network above is present, and only the load-use stall applies.
- `IDEX_FWD_EN` undefined: no bypass; the operand is always `rf_regN` (or 0 for x0).
  - `stall` is raised on any EX, MEM or WB match of a used operand.
  - The dependent instruction waits until the producer's write-back has completed.

## Test plan
- **Reset:** reset asserted while `ex_valid`=1 → all `ex_*` outputs 0 immediately; after release, `id_ready`=1.
- **Back-to-back ALU:** `addi x1,x0,5` then `add x2,x1,x1` with `ex_res`=5 → second instruction captured with `ex_op1`=`ex_op2`=5, no bubble (FWD_EN).
- **Load-use:** `lw x3` then `add x4,x3,x0`, with `wb_data`=0xDEADBEEF when the load reaches WB → exactly 2 cycles of `id_ready`=0 and `ex_valid`=0 bubbles, then `ex_op1`=0xDEADBEEF.
- **Write-back bypass:** `wb_wen`=1, `wb_rd`=7, `wb_data`=0x1234 while `rf_reg1`=0 and rs1=7 → `ex_op1`=0x1234.
  - Same stimulus with rs1=0 → `ex_op1`=0.
- **Backpressure then flush:** `ex_ready`=0 for 3 cycles → `ex_*` fields stable and `id_ready`=0; then `flush`=1 → `ex_valid`=0 next cycle and nothing accepted during the flush cycle.
- **Without `IDEX_FWD_EN`:** `addi x1` then `add x2,x1` → stall until the `wb_wen`/`wb_rd`=1 cycle has passed; operand then comes from `rf_reg1`.
